// File: rtl/riscv_core_dcache_controller_nway_pkg.sv
// riscv_core_dcache_pkg
// Shared definitions for the N-way data-cache controller: controller state
// encoding, access-size encodings, the store strobe mask and the two
// misalignment checks (plain accesses vs. LR/SC/AMO).
package riscv_core_dcache_pkg;

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_MEM_REQ      = 3'd1,
    S_UPDATE_CACHE = 3'd2,
    S_MEM_WRITE    = 3'd3,
    S_AMO_OP       = 3'd4,
    S_FLUSH        = 3'd5
  } state_t;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  // Byte-enable mask for the access size, moved to its lane inside the
  // 8-byte word. Bits shifted past lane 7 are dropped; such an access
  // faults anyway.
  function automatic logic [7:0] strobe_mask(input logic [1:0] size,
                                             input logic [2:0] off);
    logic [7:0] m;
    case (size)
      SIZE_B:  m = 8'h01;
      SIZE_H:  m = 8'h03;
      SIZE_W:  m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << off;
  endfunction

  // A plain load/store faults only if it spills over the 8-byte word.
  function automatic logic plain_fault(input logic [1:0] size,
                                       input logic [2:0] off);
    logic [3:0] end_b;
    end_b = {1'b0, off} + (4'd1 << size);
    return end_b > 4'd8;
  endfunction

  // LR/SC/AMO must be word or doubleword and naturally aligned.
  function automatic logic atomic_fault(input logic [1:0] size,
                                        input logic [2:0] off);
    case (size)
      SIZE_W:  return off[1:0] != 2'b00;
      SIZE_D:  return off != 3'b000;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/riscv_core_dcache_controller_nway_if.sv
// riscv_core_dcache_controller_nway_if
// Memory-side bus between the cache controller (master) and the AXI
// read/write channel adapters (slave).
// Handshake: a request (o_mem_read_req / o_mem_write_valid) is raised and
// held, with address/data/strobe stable, until the adapter answers with a
// single-cycle done pulse (i_mem_read_done / i_mem_write_done); the request
// drops in the cycle after the done. A done without a pending request is
// ignored by the master.
interface riscv_core_dcache_controller_nway_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0]   o_mem_read_address;
  logic                    o_mem_read_req;
  logic                    i_mem_read_done;
  logic                    o_mem_write_valid;
  logic                    i_mem_write_done;
  logic [ADDR_WIDTH-1:0]   o_mem_write_address;
  logic [DATA_WIDTH-1:0]   o_mem_write_data;
  logic [DATA_WIDTH/8-1:0] o_mem_write_strobe;

  modport master (
    output o_mem_read_address, o_mem_read_req, o_mem_write_valid,
           o_mem_write_address, o_mem_write_data, o_mem_write_strobe,
    input  i_mem_read_done, i_mem_write_done
  );

  modport slave (
    input  o_mem_read_address, o_mem_read_req, o_mem_write_valid,
           o_mem_write_address, o_mem_write_data, o_mem_write_strobe,
    output i_mem_read_done, i_mem_write_done
  );
endinterface

// File: rtl/riscv_core_dcache_controller_nway_tag_array.sv
// riscv_core_dcache_tag_array
// Tag, valid and round-robin storage for every set. Compares the request tag
// against all ways of the indexed set, encodes the hit way and picks the
// refill victim (lowest invalid way, otherwise the set's round-robin way).
// Ports: clk_i/rst_i; index_i/tag_i lookup key; hit_o, hit_way_o,
// victim_way_o lookup results; fill_en_i writes tag_i into the victim way of
// index_i; clear_en_i/clear_index_i invalidate a whole set.
module riscv_core_dcache_tag_array #(
  parameter int NUM_SETS = 128,
  parameter int NUM_WAYS = 2,
  parameter int INDEX_W  = 7,
  parameter int TAG_W    = 52,
  parameter int WAY_W    = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [INDEX_W-1:0] index_i,
  input  logic [TAG_W-1:0]   tag_i,
  output logic               hit_o,
  output logic [WAY_W-1:0]   hit_way_o,
  output logic [WAY_W-1:0]   victim_way_o,
  input  logic               fill_en_i,
  input  logic               clear_en_i,
  input  logic [INDEX_W-1:0] clear_index_i
);

  logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [WAY_W-1:0]    rr_q    [NUM_SETS];
  logic                found_free;

  always_comb begin
    hit_o        = 1'b0;
    hit_way_o    = '0;
    found_free   = 1'b0;
    victim_way_o = rr_q[index_i];
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[index_i][w] && (tag_q[index_i][w] == tag_i)) begin
        hit_o     = 1'b1;
        hit_way_o = WAY_W'(w);
      end
      if (!valid_q[index_i][w] && !found_free) begin
        found_free   = 1'b1;
        victim_way_o = WAY_W'(w);
      end
    end
  end

  // Tags need no reset: a tag is only trusted when its valid bit is set.
  always_ff @(posedge clk_i) begin
    if (fill_en_i) tag_q[index_i][victim_way_o] <= tag_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      if (clear_en_i) valid_q[clear_index_i] <= '0;
      if (fill_en_i) begin
        valid_q[index_i][victim_way_o] <= 1'b1;
        // The pointer moves on every replacement in the set, wrapping at
        // NUM_WAYS (a single-way cache always stays at 0).
        rr_q[index_i] <= (rr_q[index_i] == WAY_W'(NUM_WAYS - 1)) ? '0
                       : rr_q[index_i] + 1'b1;
      end
    end
  end

endmodule

// File: rtl/riscv_core_dcache_controller_nway.sv
// riscv_core_dcache_controller_nway
// N-way set-associative, write-through, allocate-on-miss data-cache
// controller between the core LSU, the data arrays and the AXI adapters.
// Ports: i_clk/i_rst; core request (i_addr_from_core, i_data_from_core,
// i_amo_alu_result, i_read/i_write/i_lr/i_sc/i_amo, i_size, i_flush);
// core responses (o_stall, o_*_fault, o_sc_result, o_flush_done);
// data-array controls (o_rd_en, o_wr_en, o_block_replace, o_amo_wr, o_way);
// mem_if memory bus (master); o_dbg_state exposes the controller state.
module riscv_core_dcache_controller_nway
  import riscv_core_dcache_pkg::*;
#(
  parameter int  ADDR_WIDTH      = 64,
  parameter int  CORE_DATA_WIDTH = 64,
  parameter int  LINE_BYTES      = 32,
  parameter int  NUM_SETS        = 128,
  parameter int  NUM_WAYS        = 2,
  localparam int OFFSET_W        = $clog2(LINE_BYTES),
  localparam int INDEX_W         = $clog2(NUM_SETS),
  localparam int TAG_W           = ADDR_WIDTH - INDEX_W - OFFSET_W,
  localparam int WAY_W           = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [ADDR_WIDTH-1:0]      i_addr_from_core,
  input  logic [CORE_DATA_WIDTH-1:0] i_data_from_core,
  input  logic [CORE_DATA_WIDTH-1:0] i_amo_alu_result,
  input  logic                       i_read,
  input  logic                       i_write,
  input  logic                       i_lr,
  input  logic                       i_sc,
  input  logic                       i_amo,
  input  logic [1:0]                 i_size,
  input  logic                       i_flush,
  output logic                       o_stall,
  output logic                       o_load_fault,
  output logic                       o_store_fault,
  output logic                       o_amo_fault,
  output logic [CORE_DATA_WIDTH-1:0] o_sc_result,
  output logic                       o_flush_done,
  output logic                       o_rd_en,
  output logic                       o_wr_en,
  output logic                       o_block_replace,
  output logic                       o_amo_wr,
  output logic [WAY_W-1:0]           o_way,
  output state_t                     o_dbg_state,
  riscv_core_dcache_controller_nway_if.master mem_if
);

  state_t                state_q, state_d;
  logic                  res_valid_q, res_valid_d;
  logic [ADDR_WIDTH-1:0] res_addr_q, res_addr_d;
  logic [1:0]            res_size_q, res_size_d;
  logic                  amo_q, amo_d;
  logic [INDEX_W-1:0]    flush_cnt_q, flush_cnt_d;

  logic             hit, fill_en, clear_en, do_flush, sc_fail, write_valid;
  logic [WAY_W-1:0] hit_way, victim_way;
  logic             pf, af, ld_f_raw, st_f_raw, amo_f_raw, any_req, req_ok;
  logic             sc_match, line_match;
  logic [CORE_DATA_WIDTH-1:0] wsrc;

  riscv_core_dcache_tag_array #(
    .NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS), .INDEX_W(INDEX_W),
    .TAG_W(TAG_W), .WAY_W(WAY_W)
  ) u_tags (
    .clk_i        (i_clk),
    .rst_i        (i_rst),
    .index_i      (i_addr_from_core[OFFSET_W +: INDEX_W]),
    .tag_i        (i_addr_from_core[ADDR_WIDTH-1 -: TAG_W]),
    .hit_o        (hit),
    .hit_way_o    (hit_way),
    .victim_way_o (victim_way),
    .fill_en_i    (fill_en),
    .clear_en_i   (clear_en),
    .clear_index_i(flush_cnt_q)
  );

  assign pf        = plain_fault(i_size, i_addr_from_core[2:0]);
  assign af        = atomic_fault(i_size, i_addr_from_core[2:0]);
  assign ld_f_raw  = (i_read & pf) | (i_lr & af);
  assign st_f_raw  = (i_write & pf) | (i_sc & af);
  assign amo_f_raw = i_amo & af;
  assign any_req   = i_read | i_write | i_lr | i_sc | i_amo;
  assign req_ok    = any_req & ~(ld_f_raw | st_f_raw | amo_f_raw);
  assign sc_match  = res_valid_q && (i_addr_from_core == res_addr_q)
                   && (i_size == res_size_q);
  assign line_match = res_valid_q && (i_addr_from_core[ADDR_WIDTH-1:OFFSET_W]
                   == res_addr_q[ADDR_WIDTH-1:OFFSET_W]);

  always_comb begin
    state_d         = state_q;
    res_valid_d     = res_valid_q;
    res_addr_d      = res_addr_q;
    res_size_d      = res_size_q;
    amo_d           = amo_q;
    flush_cnt_d     = flush_cnt_q;
    o_stall         = 1'b0;
    o_rd_en         = 1'b0;
    o_wr_en         = 1'b0;
    o_block_replace = 1'b0;
    o_amo_wr        = 1'b0;
    o_way           = hit_way;
    o_load_fault    = 1'b0;
    o_store_fault   = 1'b0;
    o_amo_fault     = 1'b0;
    o_flush_done    = 1'b0;
    sc_fail         = 1'b0;
    write_valid     = 1'b0;
    fill_en         = 1'b0;
    clear_en        = 1'b0;
    do_flush        = 1'b0;
    mem_if.o_mem_read_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_flush) begin
          do_flush = 1'b1;
        end else begin
          o_load_fault  = ld_f_raw;
          o_store_fault = st_f_raw;
          o_amo_fault   = amo_f_raw;
          if (req_ok && !hit) begin
            o_stall = 1'b1;
            state_d = S_MEM_REQ;
          end else if (req_ok && (i_read || i_lr)) begin
            o_rd_en = 1'b1;
            if (i_lr) begin
              res_valid_d = 1'b1;
              res_addr_d  = i_addr_from_core;
              res_size_d  = i_size;
            end
          end else if (req_ok && i_write) begin
            o_wr_en = 1'b1;
            o_stall = 1'b1;
            state_d = S_MEM_WRITE;
            if (line_match) res_valid_d = 1'b0;
          end else if (req_ok && i_sc) begin
            res_valid_d = 1'b0;
            if (sc_match) begin
              o_wr_en = 1'b1;
              o_stall = 1'b1;
              state_d = S_MEM_WRITE;
            end else begin
              sc_fail = 1'b1;
            end
          end else if (req_ok && i_amo) begin
            o_rd_en = 1'b1;
            o_stall = 1'b1;
            amo_d   = 1'b1;
            state_d = S_AMO_OP;
            if (line_match) res_valid_d = 1'b0;
          end
        end
      end
      S_MEM_REQ: begin
        o_stall               = 1'b1;
        mem_if.o_mem_read_req = 1'b1;
        if (mem_if.i_mem_read_done) state_d = S_UPDATE_CACHE;
      end
      S_UPDATE_CACHE: begin
        // Line is installed; back in IDLE the same request looks up again
        // and hits.
        o_stall         = 1'b1;
        o_wr_en         = 1'b1;
        o_block_replace = 1'b1;
        o_way           = victim_way;
        fill_en         = 1'b1;
        state_d         = S_IDLE;
      end
      S_AMO_OP: begin
        o_stall = 1'b1;
        o_rd_en = 1'b1;
        state_d = S_MEM_WRITE;
      end
      S_MEM_WRITE: begin
        write_valid = 1'b1;
        o_stall     = !mem_if.i_mem_write_done;
        if (mem_if.i_mem_write_done) begin
          // The AMO result reaches the array only once memory has taken it.
          o_wr_en  = amo_q;
          o_amo_wr = amo_q;
          amo_d    = 1'b0;
          state_d  = S_IDLE;
        end
      end
      S_FLUSH: do_flush = 1'b1;
      default: state_d = S_IDLE;
    endcase

    // The accepting IDLE cycle clears set 0, so the walk over all sets takes
    // exactly NUM_SETS stalled cycles with the done pulse in the last one.
    if (do_flush) begin
      o_stall  = 1'b1;
      clear_en = 1'b1;
      if (flush_cnt_q == INDEX_W'(NUM_SETS - 1)) begin
        o_flush_done = 1'b1;
        res_valid_d  = 1'b0;
        flush_cnt_d  = '0;
        state_d      = S_IDLE;
      end else begin
        flush_cnt_d = flush_cnt_q + 1'b1;
        state_d     = S_FLUSH;
      end
    end
  end

  assign wsrc        = amo_q ? i_amo_alu_result : i_data_from_core;
  assign o_sc_result = {{(CORE_DATA_WIDTH-1){1'b0}}, sc_fail};
  assign o_dbg_state = state_q;

  assign mem_if.o_mem_read_address  = {i_addr_from_core[ADDR_WIDTH-1:OFFSET_W],
                                       {OFFSET_W{1'b0}}};
  assign mem_if.o_mem_write_address = {i_addr_from_core[ADDR_WIDTH-1:3], 3'b000};
  assign mem_if.o_mem_write_valid   = write_valid;
  assign mem_if.o_mem_write_data    = write_valid
                                    ? (wsrc << {i_addr_from_core[2:0], 3'b000}) : '0;
  assign mem_if.o_mem_write_strobe  = write_valid
                                    ? strobe_mask(i_size, i_addr_from_core[2:0]) : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      res_valid_q <= 1'b0;
      res_addr_q  <= '0;
      res_size_q  <= SIZE_B;
      amo_q       <= 1'b0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      res_valid_q <= res_valid_d;
      res_addr_q  <= res_addr_d;
      res_size_q  <= res_size_d;
      amo_q       <= amo_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_riscv_core_dcache_controller_nway.sv
// Directed bench for riscv_core_dcache_controller_nway (default parameters:
// 32-byte lines, 128 sets, 2 ways). Inputs change 1 time unit after the
// rising edge and outputs are checked 1 time unit later.
module tb_riscv_core_dcache_controller_nway;
  import riscv_core_dcache_pkg::*;

  localparam int K_NONE = 0, K_READ = 1, K_WRITE = 2, K_LR = 3, K_SC = 4, K_AMO = 5;

  logic        clk, rst;
  logic [63:0] addr, wdata, amo_res, sc_result;
  logic        rd, wr, lr, sc, amo, flush;
  logic [1:0]  size;
  logic        stall, ld_f, st_f, amo_f, flush_done, rd_en, wr_en, blk_rep, amo_wr;
  logic [0:0]  way;
  state_t      dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  riscv_core_dcache_controller_nway_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) mem_if ();

  riscv_core_dcache_controller_nway dut (
    .i_clk(clk), .i_rst(rst),
    .i_addr_from_core(addr), .i_data_from_core(wdata), .i_amo_alu_result(amo_res),
    .i_read(rd), .i_write(wr), .i_lr(lr), .i_sc(sc), .i_amo(amo),
    .i_size(size), .i_flush(flush),
    .o_stall(stall), .o_load_fault(ld_f), .o_store_fault(st_f), .o_amo_fault(amo_f),
    .o_sc_result(sc_result), .o_flush_done(flush_done),
    .o_rd_en(rd_en), .o_wr_en(wr_en), .o_block_replace(blk_rep), .o_amo_wr(amo_wr),
    .o_way(way), .o_dbg_state(dbg_state), .mem_if(mem_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int kind, input logic [63:0] a, input logic [1:0] sz,
                         input logic [63:0] d);
    rd = (kind == K_READ); wr = (kind == K_WRITE); lr = (kind == K_LR);
    sc = (kind == K_SC);   amo = (kind == K_AMO);
    addr = a; size = sz; wdata = d;
    #1;
  endtask

  task automatic clear_req();
    set_req(K_NONE, 64'h0, 2'b00, 64'h0);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Completes a refill for the request already applied and missing in IDLE.
  task automatic refill_tail(input logic [63:0] line, input logic [63:0] exp_way);
    chk("miss_stall", 64'(stall), 64'd1);
    chk("miss_rd_en", 64'(rd_en), 64'd0);
    tick();
    chk("mreq_state", 64'(dbg_state), 64'(S_MEM_REQ));
    chk("mreq_req", 64'(mem_if.o_mem_read_req), 64'd1);
    chk("mreq_addr", mem_if.o_mem_read_address, line);
    tick();
    chk("mreq_hold", 64'(mem_if.o_mem_read_req), 64'd1);
    mem_if.i_mem_read_done = 1'b1; #1;
    tick();
    mem_if.i_mem_read_done = 1'b0; #1;
    chk("upd_wr_en", 64'(wr_en), 64'd1);
    chk("upd_blk_rep", 64'(blk_rep), 64'd1);
    chk("upd_way", 64'(way), exp_way);
    chk("upd_stall", 64'(stall), 64'd1);
    tick();
    chk("relook_stall", 64'(stall), 64'd0);
    chk("relook_rd_en", 64'(rd_en), 64'd1);
    chk("relook_way", 64'(way), exp_way);
    clear_req();
    tick();
  endtask

  task automatic do_refill(input logic [63:0] a, input logic [63:0] line,
                           input logic [63:0] exp_way);
    set_req(K_READ, a, SIZE_D, 64'h0);
    refill_tail(line, exp_way);
  endtask

  // scoreboard side: checks one memory write against the expected queue
  task automatic mem_write(input logic [63:0] exp_addr, input logic [63:0] exp_strb);
    logic [63:0] exp_d;
    chk("mw_valid", 64'(mem_if.o_mem_write_valid), 64'd1);
    chk("mw_addr", mem_if.o_mem_write_address, exp_addr);
    chk("mw_strb", 64'(mem_if.o_mem_write_strobe), exp_strb);
    if (exp_q.size() == 0) begin
      chk("mw_queue_empty", 64'(exp_q.size()), 64'd1);
    end else begin
      exp_d = exp_q.pop_front();
      chk("mw_data", mem_if.o_mem_write_data, exp_d);
    end
    tick();
    chk("mw_hold_stall", 64'(stall), 64'd1);
    mem_if.i_mem_write_done = 1'b1; #1;
    chk("mw_done_stall", 64'(stall), 64'd0);
  endtask

  task automatic mem_write_finish();
    tick();
    mem_if.i_mem_write_done = 1'b0;
    clear_req();
    chk("mw_back_idle", 64'(dbg_state), 64'(S_IDLE));
  endtask

  initial begin
    int n_st, n_done, done_at, guard;
    clear_req();
    flush = 1'b0; amo_res = 64'h0; rst = 1'b1;
    mem_if.i_mem_read_done = 1'b0; mem_if.i_mem_write_done = 1'b0;
    repeat (3) tick();
    rst = 1'b0; #1;

    // reset state
    chk("rst_state", 64'(dbg_state), 64'(S_IDLE));
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_mreq", 64'(mem_if.o_mem_read_req), 64'd0);
    chk("rst_mwv", 64'(mem_if.o_mem_write_valid), 64'd0);
    chk("rst_fdone", 64'(flush_done), 64'd0);

    // stray done pulses in IDLE are ignored
    mem_if.i_mem_read_done = 1'b1; mem_if.i_mem_write_done = 1'b1; #1;
    tick();
    mem_if.i_mem_read_done = 1'b0; mem_if.i_mem_write_done = 1'b0; #1;
    chk("stray_done_state", 64'(dbg_state), 64'(S_IDLE));

    // fills in set 0: 0x1000 -> way0, 0x2000 -> way1, 0x3010 -> rr way0, 0x1000 -> way1
    do_refill(64'h1000, 64'h1000, 64'd0);
    do_refill(64'h2000, 64'h2000, 64'd1);
    do_refill(64'h3010, 64'h3000, 64'd0);
    do_refill(64'h1000, 64'h1000, 64'd1);

    // store H to 0x1006 (hit in way 1)
    set_req(K_WRITE, 64'h1006, SIZE_H, 64'h0000_0000_0000_BEEF);
    exp_q.push_back(64'hBEEF_0000_0000_0000);
    chk("st_stall", 64'(stall), 64'd1);
    chk("st_wr_en", 64'(wr_en), 64'd1);
    chk("st_way", 64'(way), 64'd1);
    tick();
    chk("st_mw_wr_en", 64'(wr_en), 64'd0);
    mem_write(64'h1000, 64'hC0);
    mem_write_finish();

    // LR.D, conflicting store W, SC.D fails
    set_req(K_LR, 64'h1000, SIZE_D, 64'h0);
    chk("lr_rd_en", 64'(rd_en), 64'd1);
    chk("lr_stall", 64'(stall), 64'd0);
    tick();
    set_req(K_WRITE, 64'h1008, SIZE_W, 64'h1234_5678);
    exp_q.push_back(64'h0000_0000_1234_5678);
    tick();
    mem_write(64'h1008, 64'h0F);
    mem_write_finish();
    set_req(K_SC, 64'h1000, SIZE_D, 64'hCAFE);
    chk("sc1_result", sc_result, 64'd1);
    chk("sc1_wr_en", 64'(wr_en), 64'd0);
    chk("sc1_stall", 64'(stall), 64'd0);
    tick();

    // LR.D then SC.D succeeds
    set_req(K_LR, 64'h1000, SIZE_D, 64'h0);
    tick();
    set_req(K_SC, 64'h1000, SIZE_D, 64'hCAFE);
    exp_q.push_back(64'hCAFE);
    chk("sc2_result", sc_result, 64'd0);
    chk("sc2_wr_en", 64'(wr_en), 64'd1);
    tick();
    mem_write(64'h1000, 64'hFF);
    mem_write_finish();
    // reservation consumed: a second SC fails
    set_req(K_SC, 64'h1000, SIZE_D, 64'hCAFE);
    chk("sc3_result", sc_result, 64'd1);
    tick();

    // misalignment faults
    set_req(K_READ, 64'h1007, SIZE_H, 64'h0);
    chk("ldf_fault", 64'(ld_f), 64'd1);
    chk("ldf_stall", 64'(stall), 64'd0);
    chk("ldf_rd_en", 64'(rd_en), 64'd0);
    set_req(K_READ, 64'h1001, SIZE_H, 64'h0);
    chk("ld_inword_fault", 64'(ld_f), 64'd0);
    chk("ld_inword_rd_en", 64'(rd_en), 64'd1);
    set_req(K_AMO, 64'h1002, SIZE_W, 64'h0);
    chk("amof_fault", 64'(amo_f), 64'd1);
    chk("amof_stall", 64'(stall), 64'd0);
    set_req(K_WRITE, 64'h1004, SIZE_D, 64'h0);
    chk("stf_fault", 64'(st_f), 64'd1);
    chk("stf_wr_en", 64'(wr_en), 64'd0);
    tick();
    chk("fault_state", 64'(dbg_state), 64'(S_IDLE));

    // AMO W at 0x1000 (hit way 1)
    amo_res = 64'h0000_0000_0000_0055;
    set_req(K_AMO, 64'h1000, SIZE_W, 64'h0);
    exp_q.push_back(64'h55);
    chk("amo_rd_en", 64'(rd_en), 64'd1);
    chk("amo_stall", 64'(stall), 64'd1);
    tick();
    chk("amo_op_state", 64'(dbg_state), 64'(S_AMO_OP));
    chk("amo_op_rd_en", 64'(rd_en), 64'd1);
    tick();
    chk("amo_mw_wr_en", 64'(wr_en), 64'd0);
    mem_write(64'h1000, 64'h0F);
    chk("amo_done_wr_en", 64'(wr_en), 64'd1);
    chk("amo_done_amo_wr", 64'(amo_wr), 64'd1);
    mem_write_finish();

    // flush with a read pending
    flush = 1'b1;
    set_req(K_READ, 64'h1000, SIZE_D, 64'h0);
    chk("fl_acc_stall", 64'(stall), 64'd1);
    chk("fl_acc_rd_en", 64'(rd_en), 64'd0);
    chk("fl_acc_mreq", 64'(mem_if.o_mem_read_req), 64'd0);
    n_st = 1; n_done = 0; done_at = 0; guard = 0;
    if (flush_done) begin n_done++; done_at = n_st; end
    tick();
    flush = 1'b0; #1;
    while (dbg_state == S_FLUSH && guard < 300) begin
      if (stall) n_st++;
      if (flush_done) begin n_done++; done_at = n_st; end
      tick();
      guard++;
    end
    chk("fl_stall_cycles", 64'(n_st), 64'd128);
    chk("fl_done_pulses", 64'(n_done), 64'd1);
    chk("fl_done_last", 64'(done_at), 64'd128);
    refill_tail(64'h1000, 64'd0);

    // reset in the middle of a flush
    do_refill(64'h1FE0, 64'h1FE0, 64'd0);
    flush = 1'b1; #1;
    tick();
    flush = 1'b0;
    repeat (10) tick();
    chk("mid_fl_state", 64'(dbg_state), 64'(S_FLUSH));
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    chk("rst_fl_state", 64'(dbg_state), 64'(S_IDLE));
    chk("rst_fl_stall", 64'(stall), 64'd0);
    chk("rst_fl_fdone", 64'(flush_done), 64'd0);
    do_refill(64'h1FE0, 64'h1FE0, 64'd0);
    do_refill(64'h1000, 64'h1000, 64'd0);

    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_core_dcache_controller_nway.md
# riscv_core_dcache_controller_nway

Parametrised N-way set-associative, write-through, allocate-on-miss data-cache controller for the RV64IMAC core. It sits between the core LSU, the data-cache memory arrays and the AXI read/write channel adapters. It adds configurable way count, victim selection, lane-aligned store strobes, an explicit whole-cache flush, and reservation invalidation on conflicting stores.

## Interface
Parameters:
- ADDR_WIDTH, 64, core address width
- CORE_DATA_WIDTH, 64, core data width (fixed 64; strobe is 8 bits)
- LINE_BYTES, 32, cache line size in bytes, power of 2, ≥8; OFFSET_W = log2(LINE_BYTES)
- NUM_SETS, 128, sets, power of 2; INDEX_W = log2(NUM_SETS); TAG_W = ADDR_WIDTH-INDEX_W-OFFSET_W
- NUM_WAYS, 2, ways, power of 2, 1..8; WAY_W = max(1, log2(NUM_WAYS))

Ports. One clock; reset is synchronous and active-high.
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_addr_from_core / i_data_from_core / i_amo_alu_result  in  ADDR_WIDTH / 64 / 64  request address, store data, AMO result
- i_read, i_write, i_lr, i_sc, i_amo  in  1 each  request type (at most one high)
- i_size  in  2  00 B, 01 H, 10 W, 11 D
- i_flush  in  1  request whole-cache invalidate
- o_stall  out  1  hold core pipeline
- o_load_fault, o_store_fault, o_amo_fault  out  1  misalignment faults
- o_sc_result  out  64  1 = SC failed, 0 otherwise
- o_flush_done  out  1  one-cycle pulse at flush completion
- o_rd_en, o_wr_en, o_block_replace, o_amo_wr  out  1  data-array controls
- o_way  out  WAY_W  way addressed by the data array (hit way or victim)
- o_mem_read_address  out  ADDR_WIDTH  line-aligned refill address
- o_mem_read_req  out  1;  i_mem_read_done  in  1
- o_mem_write_valid  out  1;  i_mem_write_done  in  1
- o_mem_write_address  out  ADDR_WIDTH  address with [2:0] cleared
- o_mem_write_data  out  64  store data lane-aligned (shifted left 8·addr[2:0])
- o_mem_write_strobe  out  8  size mask shifted left by addr[2:0]

## Operation
- States: IDLE, MEM_REQ, UPDATE_CACHE, MEM_WRITE, AMO_OP, FLUSH.
- Lookup: compare the tag against all ways of the indexed set. hit = any valid match. o_way = matching way.
- Fault (combinational): a plain access faults if it crosses an 8-byte boundary. LR/SC/AMO fault unless size is W or D and naturally aligned. A faulting request drives no array or memory activity, no stall, and no state change. The fault output for its type is high in the same cycle.
- Read hit: o_rd_en, no stall. LR hit additionally records the reservation (addr, size, valid).
- Miss of any type: stall, then MEM_REQ. Hold o_mem_read_req until i_mem_read_done.
- UPDATE_CACHE (1 cycle): o_wr_en, o_block_replace, o_way = victim. Write tag and set valid. Return to IDLE, where the request re-looks-up and hits.
- Victim: lowest-index invalid way. If none is invalid, use the per-set round-robin pointer, which advances (mod NUM_WAYS) on each replacement in that set.
- Store hit / successful SC: o_wr_en in IDLE, then MEM_WRITE. Hold o_mem_write_valid until i_mem_write_done.
- SC: the reservation is cleared on every SC. It succeeds only if valid and the address and size match; on failure o_sc_result = 1 and nothing is written.
- Any store or AMO whose line address matches the reservation clears the reservation.
- AMO hit: o_rd_en, then AMO_OP (1 cycle, o_rd_en), then MEM_WRITE with data = i_amo_alu_result. On done: o_wr_en and o_amo_wr.
- Flush: accepted only in IDLE and takes priority over a simultaneous request. FLUSH clears the valid bits of one set per cycle (index counter 0..NUM_SETS-1) and holds stall. After the last set it clears the reservation, pulses o_flush_done and returns to IDLE. The pending request then proceeds.

## Timing
- Hit latency 0 (combinational enables, no stall).
- Miss latency: stall for the read-channel handshake + 1 UPDATE_CACHE cycle + 1 re-lookup cycle.
- Store: stall from the IDLE cycle until the i_mem_write_done cycle. Stall drops in the done cycle.
- Flush: exactly NUM_SETS stalled cycles. o_flush_done is high in the last one.
- Reset (any state): STATE = IDLE, all valid bits 0, round-robin pointers 0, reservation invalid, flush counter 0. All outputs 0 except combinational address passthroughs.
- A done pulse arriving in a state that is not waiting for it is ignored.

## Structure
- Package riscv_core_dcache_pkg: state enum, size encodings, strobe-mask function, fault function.
- Sub-module riscv_core_dcache_tag_array: tag/valid/round-robin storage per set, N-way compare, hit-way encode, victim select, set-clear port for flush.

## Test plan
- Reset, read 0x1000 (D): miss → MEM_REQ at 0x1000, done → UPDATE_CACHE way 0, then hit with o_rd_en and no stall.
- NUM_WAYS=2: fill 0x1000 and 0x2000 (same set), then miss on 0x3000 → victim way 0. Next miss in that set → way 1.
- Store H to 0x1006 (hit) → strobe 8'b1100_0000, data shifted 48 bits, address 0x1000, stall until done.
- LR.D 0x1000, store W 0x1008, SC.D 0x1000 → o_sc_result = 1, no o_wr_en. LR.D then SC.D → succeeds with a MEM_WRITE.
- Load H at 0x1007 → o_load_fault = 1, no stall. AMO W at 0x1002 → o_amo_fault = 1.
- i_flush with a read pending → 128 stalled cycles, o_flush_done pulse, then the read misses. Reset asserted mid-flush → IDLE, all lines invalid.
